// File: rtl/aes_pkg.sv
// Shared types for the AES block path: block/row widths, fetch FSM states,
// and the block FIFO entry layout.
package aes_pkg;

  localparam int ROWS_PER_BLOCK = 4;
  localparam int ROW_W          = 32;
  localparam int BLOCK_W        = ROWS_PER_BLOCK * ROW_W;

  typedef logic [BLOCK_W-1:0] aes_block_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  // One FIFO entry: the block plus a flag marking the final block of the job.
  typedef struct packed {
    logic       last;
    aes_block_t data;
  } fifo_entry_t;

  // row0 lands in the most significant word.
  function automatic aes_block_t pack_rows(input logic [ROW_W-1:0] r0,
                                           input logic [ROW_W-1:0] r1,
                                           input logic [ROW_W-1:0] r2,
                                           input logic [ROW_W-1:0] r3);
    return {r0, r1, r2, r3};
  endfunction

endpackage

// File: rtl/aes_block_fifo.sv
// Small synchronous FIFO of 128-bit blocks with a per-entry last tag.
// The head entry reads as zero whenever the FIFO is empty.
module aes_block_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fifo_entry_t              push_entry,
  input  logic                     pop,
  output fifo_entry_t              head_entry,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by count_q and
  // the head is masked when empty, so resetting it would only cost area.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  assign head_entry = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/aes_block_fetch.sv
// Read-side sequencer: paces the block memory read port, buffers blocks in
// a small FIFO and hands them to the AES core over valid/ready.
module aes_block_fetch
  import aes_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_blocks,
  output logic             ren,
  input  logic [ROW_W-1:0] row0,
  input  logic [ROW_W-1:0] row1,
  input  logic [ROW_W-1:0] row2,
  input  logic [ROW_W-1:0] row3,
  output logic             blk_valid,
  input  logic             blk_ready,
  output aes_block_t       blk_data,
  output logic             blk_last,
  output logic             busy,
  output logic             done
);

  localparam int               OCC_W     = $clog2(DEPTH) + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  fetch_state_e     state_q;
  fetch_state_e     state_d;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] issued_q;
  logic [CNT_W-1:0] popped_q;
  logic             done_q;

  logic             push;
  logic             pop;
  logic             push_last;
  logic             pop_last;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OCC_W-1:0] occupancy;
  fifo_entry_t      push_entry;
  fifo_entry_t      head_entry;

  // Read pacing depends only on registered state, never on blk_ready.
  assign ren  = (state_q == S_FETCH) && (occupancy < DEPTH_OCC);
  assign push = ren & ~fifo_full;

  assign push_last  = (issued_q == num_q - CNT_W'(1));
  assign push_entry = '{last: push_last, data: pack_rows(row0, row1, row2, row3)};

  assign blk_valid = ~fifo_empty;
  assign pop       = blk_valid & blk_ready;
  assign pop_last  = pop && (popped_q == num_q - CNT_W'(1));

  assign blk_data = head_entry.data;
  assign blk_last = head_entry.last;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;

  aes_block_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (occupancy)
  );

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start && (num_blocks != '0)) state_d = S_FETCH;
      S_FETCH: if (push && push_last)            state_d = S_DRAIN;
      S_DRAIN: if (pop_last)                     state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      num_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (state_q == S_IDLE) begin
        // A zero-length job completes immediately without touching memory.
        if (start) begin
          num_q    <= num_blocks;
          issued_q <= '0;
          popped_q <= '0;
          done_q   <= (num_blocks == '0);
        end
      end else begin
        if (push) issued_q <= issued_q + CNT_W'(1);
        if (pop)  popped_q <= popped_q + CNT_W'(1);
        done_q <= (state_q == S_DRAIN) && pop_last;
      end
    end
  end

endmodule

// File: tb/tb_aes_block_fetch.sv
// Directed bench for aes_block_fetch with a pointer-based block memory model.
module tb_aes_block_fetch;
  import aes_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_blocks = '0;
  logic             ren;
  logic [31:0]      row0, row1, row2, row3;
  logic             blk_valid;
  logic             blk_ready = 1'b0;
  aes_block_t       blk_data;
  logic             blk_last;
  logic             busy;
  logic             done;

  int tests = 0;
  int fails = 0;

  // Memory model: read pointer advances on every edge with ren, never resets.
  int ptr = 0;

  int           ren_cnt  = 0;
  int           stab_err = 0;
  logic         hold     = 1'b0;
  aes_block_t   held     = '0;
  logic [128:0] pop_q[$];

  always #5 clk = ~clk;

  aes_block_fetch #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_blocks (num_blocks),
    .ren        (ren),
    .row0       (row0),
    .row1       (row1),
    .row2       (row2),
    .row3       (row3),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .blk_data   (blk_data),
    .blk_last   (blk_last),
    .busy       (busy),
    .done       (done)
  );

  function automatic logic [31:0] mem_row(input int p, input int k);
    int w;
    w = 4 * p + k;
    return {8'(4 * w), 8'(4 * w + 1), 8'(4 * w + 2), 8'(4 * w + 3)};
  endfunction

  function automatic logic [127:0] exp_block(input int p);
    return {mem_row(p, 0), mem_row(p, 1), mem_row(p, 2), mem_row(p, 3)};
  endfunction

  assign row0 = mem_row(ptr, 0);
  assign row1 = mem_row(ptr, 1);
  assign row2 = mem_row(ptr, 2);
  assign row3 = mem_row(ptr, 3);

  always @(posedge clk) begin
    if (ren === 1'b1) ptr <= ptr + 1;
  end

  // Monitor at the falling edge: counts reads, records pops, checks hold.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ren === 1'b1) ren_cnt++;
      if (blk_valid === 1'b1 && blk_ready === 1'b1) pop_q.push_back({blk_last, blk_data});
      if (hold && blk_data !== held) stab_err++;
      hold = blk_valid & ~blk_ready;
      held = blk_data;
    end else begin
      hold = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [128:0] observed, input logic [128:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run until done (or bound), optionally toggling blk_ready at random.
  task automatic wait_done(input string tag, input int bound, input bit rand_ready);
    int c;
    c = 0;
    while (done !== 1'b1 && c < bound) begin
      if (rand_ready) blk_ready = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    check({tag, "_done"}, 129'(done), 129'(1));
    check({tag, "_busy_at_done"}, 129'(busy), 129'(0));
    tick();
    check({tag, "_done_one_cycle"}, 129'(done), 129'(0));
  endtask

  task automatic check_pops(input string tag, input int first, input int base, input int n);
    check({tag, "_pop_count"}, 129'(pop_q.size() - first), 129'(n));
    for (int i = 0; i < n && first + i < pop_q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), 129'(pop_q[first + i][127:0]), 129'(exp_block(base + i)));
      check($sformatf("%s_last%0d", tag, i), 129'(pop_q[first + i][128]), 129'(i == n - 1));
    end
  endtask

  initial begin
    int base;
    int rbase;
    int pbase;
    int p0;

    // Reset state
    tick();
    tick();
    check("rst_ren", 129'(ren), 129'(0));
    check("rst_valid", 129'(blk_valid), 129'(0));
    check("rst_data", 129'(blk_data), 129'(0));
    check("rst_last", 129'(blk_last), 129'(0));
    check("rst_busy", 129'(busy), 129'(0));
    check("rst_done", 129'(done), 129'(0));
    rst_n = 1'b1;
    tick();

    // Three blocks, ready held high: one block per cycle
    rbase = ren_cnt; pbase = pop_q.size();
    start = 1'b1; num_blocks = 16'd3; blk_ready = 1'b1;
    tick();
    start = 1'b0;
    base = ptr;
    check("t1_busy", 129'(busy), 129'(1));
    check("t1_ren", 129'(ren), 129'(1));
    check("t1_valid0", 129'(blk_valid), 129'(0));
    tick();
    check("t1_b0_valid", 129'(blk_valid), 129'(1));
    check("t1_b0_data", 129'(blk_data), 129'(exp_block(base)));
    check("t1_b0_last", 129'(blk_last), 129'(0));
    tick();
    check("t1_b1_data", 129'(blk_data), 129'(exp_block(base + 1)));
    check("t1_b1_last", 129'(blk_last), 129'(0));
    tick();
    check("t1_b2_data", 129'(blk_data), 129'(exp_block(base + 2)));
    check("t1_b2_last", 129'(blk_last), 129'(1));
    check("t1_b2_ren", 129'(ren), 129'(0));
    tick();
    check("t1_done", 129'(done), 129'(1));
    check("t1_busy_done", 129'(busy), 129'(0));
    check("t1_valid_done", 129'(blk_valid), 129'(0));
    tick();
    check("t1_done_low", 129'(done), 129'(0));
    check("t1_ren_cnt", 129'(ren_cnt - rbase), 129'(3));
    check_pops("t1", pbase, base, 3);

    // Five blocks with back-pressure: FIFO fills, then resumes after a pop
    rbase = ren_cnt; pbase = pop_q.size();
    start = 1'b1; num_blocks = 16'd5; blk_ready = 1'b0;
    tick();
    start = 1'b0;
    base = ptr;
    repeat (4) tick();
    check("t2_stall_ren", 129'(ren), 129'(0));
    check("t2_stall_cnt", 129'(ren_cnt - rbase), 129'(DEPTH));
    check("t2_stall_valid", 129'(blk_valid), 129'(1));
    check("t2_stall_data", 129'(blk_data), 129'(exp_block(base)));
    repeat (3) tick();
    check("t2_stable_data", 129'(blk_data), 129'(exp_block(base)));
    check("t2_stable_last", 129'(blk_last), 129'(0));
    blk_ready = 1'b1;
    check("t2_full_ren", 129'(ren), 129'(0));
    tick();
    check("t2_resume_ren", 129'(ren), 129'(1));
    wait_done("t2", 40, 1'b0);
    check("t2_ren_cnt", 129'(ren_cnt - rbase), 129'(5));
    check_pops("t2", pbase, base, 5);

    // Sixteen blocks with random ready
    rbase = ren_cnt; pbase = pop_q.size();
    start = 1'b1; num_blocks = 16'd16; blk_ready = 1'b0;
    tick();
    start = 1'b0;
    base = ptr;
    wait_done("t3", 600, 1'b1);
    blk_ready = 1'b1;
    check("t3_ren_cnt", 129'(ren_cnt - rbase), 129'(16));
    check_pops("t3", pbase, base, 16);

    // Zero-length job
    rbase = ren_cnt; p0 = ptr;
    start = 1'b1; num_blocks = 16'd0;
    tick();
    start = 1'b0;
    check("t4_done", 129'(done), 129'(1));
    check("t4_busy", 129'(busy), 129'(0));
    check("t4_ren", 129'(ren), 129'(0));
    tick();
    check("t4_done_low", 129'(done), 129'(0));
    check("t4_busy_low", 129'(busy), 129'(0));
    tick();
    check("t4_ren_cnt", 129'(ren_cnt - rbase), 129'(0));
    check("t4_ptr", 129'(ptr), 129'(p0));

    // start while busy is ignored
    rbase = ren_cnt; pbase = pop_q.size();
    start = 1'b1; num_blocks = 16'd4; blk_ready = 1'b0;
    tick();
    start = 1'b0;
    base = ptr;
    tick();
    start = 1'b1; num_blocks = 16'd9;
    tick();
    start = 1'b0;
    check("t5_busy", 129'(busy), 129'(1));
    tick();
    blk_ready = 1'b1;
    wait_done("t5", 40, 1'b0);
    check("t5_ren_cnt", 129'(ren_cnt - rbase), 129'(4));
    check_pops("t5", pbase, base, 4);

    // Reset during FETCH with one block buffered, then a clean job
    start = 1'b1; num_blocks = 16'd6; blk_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    check("t6_one_buffered", 129'(blk_valid), 129'(1));
    check("t6_fetching", 129'(ren), 129'(1));
    rst_n = 1'b0;
    tick();
    check("t6_rst_valid", 129'(blk_valid), 129'(0));
    check("t6_rst_ren", 129'(ren), 129'(0));
    check("t6_rst_busy", 129'(busy), 129'(0));
    check("t6_rst_data", 129'(blk_data), 129'(0));
    check("t6_rst_done", 129'(done), 129'(0));
    rst_n = 1'b1;
    tick();
    rbase = ren_cnt; pbase = pop_q.size();
    start = 1'b1; num_blocks = 16'd2; blk_ready = 1'b1;
    tick();
    start = 1'b0;
    base = ptr;
    wait_done("t6", 40, 1'b0);
    check("t6_ren_cnt", 129'(ren_cnt - rbase), 129'(2));
    check_pops("t6", pbase, base, 2);

    check("hold_stability", 129'(stab_err), 129'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
